// File: rtl/switch_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : switch_led_sequencer
// Brief    : Debounces four board switches and drives four LEDs through a
//            DIRECT / CHASE / BLINK / HOLD pattern state machine.
// Revision : 1.0
// ============================================================================
module switch_led_sequencer #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int STEP_LIMIT     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int c_STEP_W = $clog2(STEP_LIMIT + 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_LIMIT - 1);

    localparam logic [1:0] c_MODE_DIRECT = 2'd0;
    localparam logic [1:0] c_MODE_CHASE  = 2'd1;
    localparam logic [1:0] c_MODE_BLINK  = 2'd2;
    localparam logic [1:0] c_MODE_HOLD   = 2'd3;

    logic [3:0] w_raw;
    logic [3:0] w_db;
    logic [3:0] r_db_q;
    logic [3:0] r_press;

    assign w_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic              r_db;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    r_db  <= 1'b0;
                    r_cnt <= '0;
                end else if (w_raw[gi] != r_db) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_db  <= w_raw[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_db[gi] = r_db;
        end
    endgenerate

    // Press events fire one cycle after the debounced level rises.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_db_q  <= 4'b0000;
            r_press <= 4'b0000;
        end else begin
            r_db_q  <= w_db;
            r_press <= w_db & ~r_db_q;
        end
    end

    logic [1:0]          r_mode;
    logic [3:0]          r_pattern;
    logic                r_reverse;
    logic                r_paused;
    logic [c_STEP_W-1:0] r_step;
    logic [3:0]          r_led;

    logic [1:0]          w_mode_nxt;
    logic [3:0]          w_pattern_nxt;
    logic                w_reverse_nxt;
    logic                w_paused_nxt;
    logic [c_STEP_W-1:0] w_step_nxt;
    logic                w_running;

    assign w_running = ((r_mode == c_MODE_CHASE) || (r_mode == c_MODE_BLINK)) && !r_paused;

    always_comb begin
        w_mode_nxt    = r_mode;
        w_pattern_nxt = r_pattern;
        w_reverse_nxt = r_reverse;
        w_paused_nxt  = r_paused;
        w_step_nxt    = r_step;
        if (r_press[3] || r_press[0]) begin
            // Switch 4 outranks switch 1; HOLD keeps the pattern already shown.
            w_mode_nxt   = r_press[3] ? c_MODE_DIRECT : r_mode + 2'd1;
            w_step_nxt   = '0;
            w_paused_nxt = 1'b0;
            if (w_mode_nxt == c_MODE_CHASE) begin
                w_pattern_nxt = 4'b0001;
                w_reverse_nxt = 1'b0;
            end else if (w_mode_nxt == c_MODE_BLINK) begin
                w_pattern_nxt = 4'b1111;
            end
        end else begin
            if (w_running) begin
                if (r_step == c_STEP_LAST) begin
                    w_step_nxt = '0;
                    if (r_mode == c_MODE_CHASE) begin
                        w_pattern_nxt = r_reverse ? {r_pattern[0], r_pattern[3:1]}
                                                  : {r_pattern[2:0], r_pattern[3]};
                    end else begin
                        w_pattern_nxt = ~r_pattern;
                    end
                end else begin
                    w_step_nxt = r_step + c_STEP_W'(1);
                end
            end
            if ((r_mode == c_MODE_CHASE) && r_press[1]) begin
                w_reverse_nxt = ~r_reverse;
            end
            if (((r_mode == c_MODE_CHASE) || (r_mode == c_MODE_BLINK)) && r_press[2]) begin
                w_paused_nxt = ~r_paused;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_mode    <= c_MODE_DIRECT;
            r_pattern <= 4'b0000;
            r_reverse <= 1'b0;
            r_paused  <= 1'b0;
            r_step    <= '0;
            r_led     <= 4'b0000;
        end else begin
            r_mode    <= w_mode_nxt;
            r_pattern <= w_pattern_nxt;
            r_reverse <= w_reverse_nxt;
            r_paused  <= w_paused_nxt;
            r_step    <= w_step_nxt;
            r_led     <= (w_mode_nxt == c_MODE_DIRECT) ? w_db : w_pattern_nxt;
        end
    end

    assign o_LED_1 = r_led[0];
    assign o_LED_2 = r_led[1];
    assign o_LED_3 = r_led[2];
    assign o_LED_4 = r_led[3];
    assign o_Mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_switch_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_led_sequencer
// Brief    : Directed plus random stimulus against a behavioural LED model.
// Revision : 1.0
// ============================================================================
module tb_switch_led_sequencer;

    localparam int c_DB   = 4;
    localparam int c_STEP = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       led1, led2, led3, led4;
    logic [1:0] mode;
    logic [3:0] leds;

    int total = 0;
    int bad   = 0;

    assign leds = {led4, led3, led2, led1};

    switch_led_sequencer #(
        .DEBOUNCE_LIMIT(c_DB),
        .STEP_LIMIT    (c_STEP)
    ) u_dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Switch_1(sw[0]),
        .i_Switch_2(sw[1]),
        .i_Switch_3(sw[2]),
        .i_Switch_4(sw[3]),
        .o_LED_1   (led1),
        .o_LED_2   (led2),
        .o_LED_3   (led3),
        .o_LED_4   (led4),
        .o_Mode    (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: switches as level + run length, chase as a lit-LED index,
    // blink as an on/off flag.
    logic [3:0] m_db, m_prev, m_evt, m_led, m_hold;
    int         m_run [4];
    logic [1:0] m_mode;
    int         m_pos, m_ticks;
    bit         m_rev, m_on, m_paused;

    function automatic logic [3:0] shown();
        case (m_mode)
            2'd1:    return 4'(1 << m_pos);
            2'd2:    return m_on ? 4'hF : 4'h0;
            2'd3:    return m_hold;
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_db = 0; m_prev = 0; m_evt = 0; m_led = 0; m_hold = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_mode = 0; m_pos = 0; m_ticks = 0; m_rev = 0; m_on = 0; m_paused = 0;
    endtask

    task automatic model_update(input logic [3:0] raw);
        logic [3:0] evt_old, db_old, pat_old;
        evt_old = m_evt;
        db_old  = m_db;
        pat_old = shown();
        m_evt   = m_db & ~m_prev;
        m_prev  = m_db;
        for (int i = 0; i < 4; i++) begin
            if (raw[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == c_DB) begin
                    m_db[i]  = raw[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (evt_old[3] || evt_old[0]) begin
            m_mode   = evt_old[3] ? 2'd0 : m_mode + 2'd1;
            m_ticks  = 0;
            m_paused = 0;
            if (m_mode == 2'd1) begin m_pos = 0; m_rev = 0; end
            if (m_mode == 2'd2) m_on = 1;
            if (m_mode == 2'd3) m_hold = pat_old;
        end else begin
            if ((m_mode == 2'd1 || m_mode == 2'd2) && !m_paused) begin
                m_ticks++;
                if (m_ticks == c_STEP) begin
                    m_ticks = 0;
                    if (m_mode == 2'd1) m_pos = m_rev ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
                    else                m_on  = !m_on;
                end
            end
            if (m_mode == 2'd1 && evt_old[1]) m_rev = !m_rev;
            if ((m_mode == 2'd1 || m_mode == 2'd2) && evt_old[2]) m_paused = !m_paused;
        end
        m_led = (m_mode == 2'd0) ? db_old : shown();
    endtask

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update(sw);
        #1;
        check_val("leds", leds, m_led);
        check_val("mode", {2'b00, mode}, {2'b00, m_mode});
    endtask

    task automatic press(input logic [3:0] mask, input int hi, input int lo);
        sw = mask;
        repeat (hi) tick();
        sw = 4'b0000;
        repeat (lo) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 4'b0000;
        model_reset();
        repeat (3) tick();
        #2 rst_n = 1'b1;
        repeat (20) tick();
        check_val("idle_leds", leds, 4'b0000);

        press(4'b0010, 3, 10);
        check_val("glitch_leds", leds, 4'b0000);
        check_val("glitch_mode", {2'b00, mode}, 4'b0000);

        sw = 4'b0010;
        repeat (4) tick();
        check_val("led2_before", leds, 4'b0000);
        tick();
        check_val("led2_on", leds, 4'b0010);
        repeat (5) tick();
        sw = 4'b0000;
        repeat (10) tick();
        check_val("led2_off", leds, 4'b0000);

        press(4'b0001, 6, 4);
        check_val("chase_mode", {2'b00, mode}, 4'b0001);
        repeat (14) tick();
        press(4'b0010, 6, 3);
        repeat (14) tick();

        press(4'b0001, 6, 4);
        check_val("blink_mode", {2'b00, mode}, 4'b0010);
        repeat (10) tick();
        press(4'b0100, 6, 10);
        press(4'b0100, 6, 10);

        press(4'b0001, 6, 6);
        check_val("hold_mode", {2'b00, mode}, 4'b0011);
        press(4'b0001, 6, 4);
        press(4'b0001, 6, 5);
        press(4'b1001, 6, 6);
        check_val("prio_mode", {2'b00, mode}, 4'b0000);

        press(4'b0001, 6, 4);
        tick();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_leds", leds, 4'b0000);
        check_val("async_mode", {2'b00, mode}, 4'b0000);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (4) tick();

        repeat (80) begin
            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) sw[3] = 1'b0;
            repeat ($urandom_range(1, 10)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
